// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : alu_pkg
//  Purpose  : Shared constants and types for the ALU decode-and-issue stage.
//  Revision : 1.0 - initial release
// ============================================================================
package alu_pkg;

  // ALU operation codes presented to the execute stage
  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SLL  = 4'b0001;
  localparam logic [3:0] OP_SLT  = 4'b0010;
  localparam logic [3:0] OP_SLTU = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_OR   = 4'b0110;
  localparam logic [3:0] OP_AND  = 4'b0111;
  localparam logic [3:0] OP_SUB  = 4'b1000;
  localparam logic [3:0] OP_SRA  = 4'b1101;

  // RV32I major opcodes handled by this stage
  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;

  // funct7 encodings: base form and the sub/sra alternate form
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // One decoded, issue-ready instruction
  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    logic [4:0]  rd;
    logic        rd_we;
    logic        illegal;
  } issue_entry_t;

  // The alternate-form bit lands in op[3]; funct3 fills the low bits
  function automatic logic [3:0] f3_to_op(input logic [2:0] f3, input logic alt);
    return {alt, f3};
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_issue_if.sv
`default_nettype none
// ============================================================================
//  Module   : alu_issue_if
//  Purpose  : Upstream (instruction) and downstream (ALU) handshake bundle
//             of the decode-and-issue stage.
//  Revision : 1.0 - initial release
// ============================================================================
interface alu_issue_if;
  // upstream side
  logic        in_valid;
  logic        in_ready;
  logic [31:0] inst;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  // downstream side
  logic        out_valid;
  logic        out_ready;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [3:0]  alu_op;
  logic [4:0]  rd;
  logic        rd_we;
  logic        illegal;

  // environment view: produces instructions, consumes issued ops
  modport master (
    output in_valid, inst, rs1_data, rs2_data, out_ready,
    input  in_ready, out_valid, alu_a, alu_b, alu_op, rd, rd_we, illegal
  );

  // issue-stage view
  modport slave (
    input  in_valid, inst, rs1_data, rs2_data, out_ready,
    output in_ready, out_valid, alu_a, alu_b, alu_op, rd, rd_we, illegal
  );
endinterface
`default_nettype wire

// File: rtl/alu_decode.sv
`default_nettype none
// ============================================================================
//  Module   : alu_decode
//  Purpose  : Combinational RV32I integer-ALU decoder producing operands,
//             ALU op, destination and an illegal flag.
//  Revision : 1.0 - initial release
// ============================================================================
module alu_decode
  import alu_pkg::*;
(
  input  wire logic [31:0] inst_i,
  input  wire logic [31:0] rs1_data_i,
  input  wire logic [31:0] rs2_data_i,
  output issue_entry_t     entry_o
);

  logic [6:0] opcode;
  logic [2:0] f3;
  logic [6:0] f7;
  logic       legal;
  logic [31:0] a_raw;
  logic [31:0] b_raw;
  logic [3:0]  op_raw;

  assign opcode = inst_i[6:0];
  assign f3     = inst_i[14:12];
  assign f7     = inst_i[31:25];

  // rs1 index is resolved by the register file upstream, not needed here
  logic unused_rs1_idx;
  assign unused_rs1_idx = ^inst_i[19:15];

  // Classify the instruction and select raw operands/op
  always_comb begin
    legal  = 1'b0;
    a_raw  = rs1_data_i;
    b_raw  = rs2_data_i;
    op_raw = OP_ADD;
    case (opcode)
      OPC_OP: begin
        legal  = (f7 == F7_BASE) ||
                 ((f7 == F7_ALT) && ((f3 == 3'b000) || (f3 == 3'b101)));
        op_raw = f3_to_op(f3, f7 == F7_ALT);
      end
      OPC_OPIMM: begin
        case (f3)
          3'b001: begin
            legal  = (f7 == F7_BASE);
            b_raw  = {27'b0, inst_i[24:20]};
            op_raw = OP_SLL;
          end
          3'b101: begin
            legal  = (f7 == F7_BASE) || (f7 == F7_ALT);
            b_raw  = {27'b0, inst_i[24:20]};
            op_raw = f3_to_op(f3, f7 == F7_ALT);
          end
          default: begin
            // addi has no sub form, so op[3] is always clear here
            legal  = 1'b1;
            b_raw  = {{20{inst_i[31]}}, inst_i[31:20]};
            op_raw = f3_to_op(f3, 1'b0);
          end
        endcase
      end
      default: legal = 1'b0;
    endcase
  end

  // Illegal entries still issue, but carry neutral operands and no write
  always_comb begin
    entry_o.rd      = inst_i[11:7];
    entry_o.illegal = ~legal;
    entry_o.a       = legal ? a_raw  : 32'd0;
    entry_o.b       = legal ? b_raw  : 32'd0;
    entry_o.op      = legal ? op_raw : OP_ADD;
    entry_o.rd_we   = legal && (inst_i[11:7] != 5'd0);
  end

endmodule
`default_nettype wire

// File: rtl/alu_issue.sv
`default_nettype none
// ============================================================================
//  Module   : alu_issue
//  Purpose  : Decode-and-issue stage: decodes RV32I ALU instructions and
//             buffers them in a 2-entry FIFO ahead of the ALU.
//  Revision : 1.0 - initial release
// ============================================================================
module alu_issue
  import alu_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  wire logic   clk,
  input  wire logic   rst,
  input  wire logic   flush,
  alu_issue_if.slave  bus
);

  issue_entry_t dec_entry;
  issue_entry_t mem_q [DEPTH];
  issue_entry_t head;
  logic [1:0]   count_q, count_d;
  logic         wptr_q, wptr_d;
  logic         rptr_q, rptr_d;
  logic         push, pop;

  alu_decode u_decode (
    .inst_i     (bus.inst),
    .rs1_data_i (bus.rs1_data),
    .rs2_data_i (bus.rs2_data),
    .entry_o    (dec_entry)
  );

  // in_ready depends only on stored count, so a pop never opens a full buffer early
  assign bus.in_ready  = (count_q != 2'(DEPTH));
  assign bus.out_valid = (count_q != 2'd0);
  assign push          = bus.in_valid && bus.in_ready && !flush;
  assign pop           = bus.out_valid && bus.out_ready;

  assign head          = mem_q[rptr_q];
  assign bus.alu_a     = head.a;
  assign bus.alu_b     = head.b;
  assign bus.alu_op    = head.op;
  assign bus.rd        = head.rd;
  assign bus.rd_we     = head.rd_we;
  assign bus.illegal   = head.illegal;

  // Next pointer/count state; flush empties the buffer and drops any push
  always_comb begin
    count_d = count_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    if (flush) begin
      count_d = 2'd0;
      wptr_d  = 1'b0;
      rptr_d  = 1'b0;
    end else begin
      if (push) wptr_d = ~wptr_q;
      if (pop)  rptr_d = ~rptr_q;
      case ({push, pop})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  // State and storage registers; reset clears entries so outputs read zero
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= 2'd0;
      wptr_q  <= 1'b0;
      rptr_q  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      count_q <= count_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      if (push) mem_q[wptr_q] <= dec_entry;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_issue.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_issue
//  Purpose  : Directed self-checking bench for the decode-and-issue stage.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_alu_issue;

  logic clk = 1'b0;
  logic rst;
  logic flush;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  alu_issue_if bus ();

  alu_issue #(.DEPTH(2)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus)
  );

  // {out_valid, alu_op, alu_a, alu_b, rd, rd_we, illegal}
  function automatic logic [75:0] head_obs();
    return {bus.out_valid, bus.alu_op, bus.alu_a, bus.alu_b, bus.rd, bus.rd_we, bus.illegal};
  endfunction

  function automatic logic [75:0] mk(input logic v, input logic [3:0] op, input logic [31:0] a,
                                     input logic [31:0] b, input logic [4:0] rd, input logic we,
                                     input logic ill);
    return {v, op, a, b, rd, we, ill};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] i, input logic [31:0] a, input logic [31:0] b);
    bus.in_valid = v;
    bus.inst     = i;
    bus.rs1_data = a;
    bus.rs2_data = b;
  endtask

  task automatic test_reset();
    logic [75:0] exp;
    rst = 1'b1;
    flush = 1'b0;
    bus.out_ready = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 32'h0);
    tick();
    tick();
    rst = 1'b0;
    exp = mk(1'b0, 4'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
    checks++;
    if (head_obs() !== exp) begin
      errors++;
      $display("FAIL reset_outputs got %h want %h", head_obs(), exp);
    end
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready got %b want 1", bus.in_ready);
    end
  endtask

  task automatic test_add();
    logic [75:0] exp;
    bus.out_ready = 1'b0;
    drive(1'b1, 32'h002081B3, 32'd5, 32'd7);
    #1;
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL add_no_bypass got %b want 0", bus.out_valid);
    end
    tick();
    drive(1'b0, 32'h0, 32'h0, 32'h0);
    exp = mk(1'b1, 4'h0, 32'd5, 32'd7, 5'd3, 1'b1, 1'b0);
    checks++;
    if (head_obs() !== exp) begin
      errors++;
      $display("FAIL add_head got %h want %h", head_obs(), exp);
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL add_popped got %b want 0", bus.out_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [75:0] exp;
    bus.out_ready = 1'b1;
    drive(1'b1, 32'h402081B3, 32'd10, 32'd3);
    tick();
    exp = mk(1'b1, 4'h8, 32'd10, 32'd3, 5'd3, 1'b1, 1'b0);
    checks++;
    if (head_obs() !== exp) begin
      errors++;
      $display("FAIL b2b_sub got %h want %h", head_obs(), exp);
    end
    drive(1'b1, 32'hFFF00093, 32'd0, 32'h55);
    tick();
    drive(1'b0, 32'h0, 32'h0, 32'h0);
    exp = mk(1'b1, 4'h0, 32'd0, 32'hFFFFFFFF, 5'd1, 1'b1, 1'b0);
    checks++;
    if (head_obs() !== exp) begin
      errors++;
      $display("FAIL b2b_addi got %h want %h", head_obs(), exp);
    end
    tick();
    bus.out_ready = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_drain got %b want 0", bus.out_valid);
    end
  endtask

  task automatic test_decode();
    logic [31:0] v_inst [8];
    logic [31:0] v_rs1  [8];
    logic [31:0] v_rs2  [8];
    logic [75:0] v_exp  [8];
    // srai x5,x6,3
    v_inst[0] = 32'h40335293; v_rs1[0] = 32'h80000000; v_rs2[0] = 32'hAA;
    v_exp[0]  = mk(1'b1, 4'hD, 32'h80000000, 32'd3, 5'd5, 1'b1, 1'b0);
    // slli with inst[30] set: illegal
    v_inst[1] = 32'h40331293; v_rs1[1] = 32'h80000000; v_rs2[1] = 32'hAA;
    v_exp[1]  = mk(1'b1, 4'h0, 32'h0, 32'h0, 5'd5, 1'b0, 1'b1);
    // srli x5,x6,3
    v_inst[2] = 32'h00335293; v_rs1[2] = 32'hF0; v_rs2[2] = 32'hAA;
    v_exp[2]  = mk(1'b1, 4'h5, 32'hF0, 32'd3, 5'd5, 1'b1, 1'b0);
    // xor with alternate funct7: illegal
    v_inst[3] = 32'h4020C1B3; v_rs1[3] = 32'd1; v_rs2[3] = 32'd2;
    v_exp[3]  = mk(1'b1, 4'h0, 32'h0, 32'h0, 5'd3, 1'b0, 1'b1);
    // add x0,x1,x2: legal, no write
    v_inst[4] = 32'h00208033; v_rs1[4] = 32'd9; v_rs2[4] = 32'd4;
    v_exp[4]  = mk(1'b1, 4'h0, 32'd9, 32'd4, 5'd0, 1'b0, 1'b0);
    // sra x3,x1,x2
    v_inst[5] = 32'h4020D1B3; v_rs1[5] = 32'h11; v_rs2[5] = 32'h22;
    v_exp[5]  = mk(1'b1, 4'hD, 32'h11, 32'h22, 5'd3, 1'b1, 1'b0);
    // andi x2,x1,-2048
    v_inst[6] = 32'h8000F113; v_rs1[6] = 32'h1234; v_rs2[6] = 32'h99;
    v_exp[6]  = mk(1'b1, 4'h7, 32'h1234, 32'hFFFFF800, 5'd2, 1'b1, 1'b0);
    // load opcode: illegal
    v_inst[7] = 32'h00208003; v_rs1[7] = 32'd8; v_rs2[7] = 32'd8;
    v_exp[7]  = mk(1'b1, 4'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b1);
    bus.out_ready = 1'b0;
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, v_inst[k], v_rs1[k], v_rs2[k]);
      tick();
      drive(1'b0, 32'h0, 32'h0, 32'h0);
      checks++;
      if (head_obs() !== v_exp[k]) begin
        errors++;
        $display("FAIL decode_%0d got %h want %h", k, head_obs(), v_exp[k]);
      end
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
    end
  endtask

  task automatic test_full();
    logic [75:0] exp;
    bus.out_ready = 1'b0;
    drive(1'b1, 32'h002080B3, 32'd1, 32'h10);
    tick();
    drive(1'b1, 32'h00208133, 32'd2, 32'h10);
    tick();
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_in_ready got %b want 0", bus.in_ready);
    end
    drive(1'b1, 32'h002081B3, 32'd3, 32'h10);
    tick();
    exp = mk(1'b1, 4'h0, 32'd1, 32'h10, 5'd1, 1'b1, 1'b0);
    checks++;
    if (head_obs() !== exp || bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_held got %h rdy %b want %h rdy 0", head_obs(), bus.in_ready, exp);
    end
    bus.out_ready = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_pop_in_ready got %b want 0", bus.in_ready);
    end
    tick();
    exp = mk(1'b1, 4'h0, 32'd2, 32'h10, 5'd2, 1'b1, 1'b0);
    checks++;
    if (head_obs() !== exp || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL full_second got %h rdy %b want %h rdy 1", head_obs(), bus.in_ready, exp);
    end
    tick();
    drive(1'b0, 32'h0, 32'h0, 32'h0);
    exp = mk(1'b1, 4'h0, 32'd3, 32'h10, 5'd3, 1'b1, 1'b0);
    checks++;
    if (head_obs() !== exp) begin
      errors++;
      $display("FAIL full_third got %h want %h", head_obs(), exp);
    end
    tick();
    bus.out_ready = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL full_drain got %b want 0", bus.out_valid);
    end
  endtask

  task automatic test_flush();
    logic [75:0] exp;
    bus.out_ready = 1'b0;
    drive(1'b1, 32'h002080B3, 32'd1, 32'h10);
    tick();
    drive(1'b1, 32'h00208133, 32'd2, 32'h10);
    tick();
    flush = 1'b1;
    drive(1'b1, 32'h002081B3, 32'd3, 32'h10);
    tick();
    flush = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_state got vld %b rdy %b want vld 0 rdy 1", bus.out_valid, bus.in_ready);
    end
    // the push presented alongside flush must not show up
    drive(1'b0, 32'h0, 32'h0, 32'h0);
    tick();
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_push_dropped got %b want 0", bus.out_valid);
    end
    drive(1'b1, 32'h00208133, 32'h77, 32'h10);
    tick();
    drive(1'b0, 32'h0, 32'h0, 32'h0);
    exp = mk(1'b1, 4'h0, 32'h77, 32'h10, 5'd2, 1'b1, 1'b0);
    checks++;
    if (head_obs() !== exp) begin
      errors++;
      $display("FAIL flush_after got %h want %h", head_obs(), exp);
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_rst_mid();
    logic [75:0] exp;
    bus.out_ready = 1'b0;
    drive(1'b1, 32'h002080B3, 32'd1, 32'h10);
    tick();
    drive(1'b1, 32'h00208133, 32'd2, 32'h10);
    tick();
    // push and pop requested during reset must both lose to reset
    rst = 1'b1;
    bus.out_ready = 1'b1;
    drive(1'b1, 32'h002081B3, 32'd3, 32'h10);
    tick();
    rst = 1'b0;
    bus.out_ready = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 32'h0);
    exp = mk(1'b0, 4'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
    checks++;
    if (head_obs() !== exp || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_state got %h rdy %b want %h rdy 1", head_obs(), bus.in_ready, exp);
    end
    tick();
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_push_dropped got %b want 0", bus.out_valid);
    end
    drive(1'b1, 32'h00000000, 32'h1234, 32'd5);
    tick();
    drive(1'b0, 32'h0, 32'h0, 32'h0);
    exp = mk(1'b1, 4'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b1);
    checks++;
    if (head_obs() !== exp) begin
      errors++;
      $display("FAIL rst_mid_zero_inst got %h want %h", head_obs(), exp);
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_add();
    test_back_to_back();
    test_decode();
    test_full();
    test_flush();
    test_rst_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
